// File: rtl/program_counter_ras.sv
// LEGv8 program counter with stall, trap redirect and a circular return-address stack.
// Next PC priority: trap, stall, pop (RAS or absolute fallback), then the PS select.
module program_counter_ras #(
    parameter int                 WIDTH        = 64,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   TRAP_VECTOR  = WIDTH'(64'h80),
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       PS,
    input  logic [WIDTH-1:0] in,
    input  logic             stall,
    input  logic             trap,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC4,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_miss
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_ABS  = 2'b01,
        PS_SEQ  = 2'b10,
        PS_REL  = 2'b11
    } ps_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             miss_q, miss_d;
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];

    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] top;
    logic             empty;
    logic             full;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    assign pc4     = pc_q + WIDTH'(INC);
    assign rel     = pc4 + {in[WIDTH-3:0], 2'b00};
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(RAS_DEPTH));
    assign top     = empty ? '0 : ras_mem_q[ptr_q];
    assign ptr_inc = ptr_q + PTR_W'(1);
    assign ptr_dec = ptr_q - PTR_W'(1);

    always_comb begin
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        miss_d    = 1'b0;
        ras_mem_d = ras_mem_q;

        if (trap) begin
            pc_d = TRAP_VECTOR;
        end else if (!stall) begin
            if (pop) begin
                if (empty) begin
                    pc_d   = in;
                    miss_d = 1'b1;
                end else begin
                    pc_d = top;
                end
            end else begin
                unique case (ps_e'(PS))
                    PS_HOLD: pc_d = pc_q;
                    PS_ABS:  pc_d = in;
                    PS_SEQ:  pc_d = pc4;
                    PS_REL:  pc_d = rel;
                    default: pc_d = pc_q;
                endcase
            end

            // A push+pop on a live stack swaps the top in place; an empty pop behaves as no pop.
            if (push && pop && !empty) begin
                ras_mem_d[ptr_q] = pc4;
            end else if (push) begin
                ptr_d            = ptr_inc;
                ras_mem_d[ptr_inc] = pc4;
                if (!full) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (pop && !empty) begin
                ptr_d   = ptr_dec;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            ptr_q   <= '0;
            count_q <= '0;
            miss_q  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            miss_q    <= miss_d;
            ras_mem_q <= ras_mem_d;
        end
    end

    assign PC        = pc_q;
    assign PC4       = pc4;
    assign ras_top   = top;
    assign ras_empty = empty;
    assign ras_full  = full;
    assign ras_miss  = miss_q;

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed, table-driven bench for program_counter_ras (WIDTH=64, RAS_DEPTH=4).
module tb_program_counter_ras;

    logic        clock;
    logic        reset;
    logic [1:0]  PS;
    logic [63:0] in;
    logic        stall;
    logic        trap;
    logic        push;
    logic        pop;
    logic [63:0] PC;
    logic [63:0] PC4;
    logic [63:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_miss;

    int checks;
    int errors;

    typedef struct {
        logic [1:0]  ps;
        logic [63:0] in_v;
        logic        stall;
        logic        trap;
        logic        push;
        logic        pop;
        logic [63:0] exp_pc;
        logic [63:0] exp_top;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_miss;
    } vec_t;

    vec_t vecs[$];

    program_counter_ras dut (
        .clock     (clock),
        .reset     (reset),
        .PS        (PS),
        .in        (in),
        .stall     (stall),
        .trap      (trap),
        .push      (push),
        .pop       (pop),
        .PC        (PC),
        .PC4       (PC4),
        .ras_top   (ras_top),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_miss  (ras_miss)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [1:0] ps, input logic [63:0] in_v,
                                input logic st, input logic tr, input logic pu, input logic po,
                                input logic [63:0] epc, input logic [63:0] etop,
                                input logic ee, input logic ef, input logic em);
        vec_t v;
        v.ps = ps; v.in_v = in_v; v.stall = st; v.trap = tr; v.push = pu; v.pop = po;
        v.exp_pc = epc; v.exp_top = etop; v.exp_empty = ee; v.exp_full = ef; v.exp_miss = em;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [63:0] epc, input logic [63:0] etop,
                            input logic ee, input logic ef, input logic em);
        checkOutput({tag, " PC"}, PC, epc);
        checkOutput({tag, " PC4"}, PC4, epc + 64'd4);
        checkOutput({tag, " ras_top"}, ras_top, etop);
        checkOutput({tag, " ras_empty"}, {63'd0, ras_empty}, {63'd0, ee});
        checkOutput({tag, " ras_full"}, {63'd0, ras_full}, {63'd0, ef});
        checkOutput({tag, " ras_miss"}, {63'd0, ras_miss}, {63'd0, em});
    endtask

    task automatic applyStimulus(input vec_t v);
        PS    = v.ps;
        in    = v.in_v;
        stall = v.stall;
        trap  = v.trap;
        push  = v.push;
        pop   = v.pop;
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ps, in, stall, trap, push, pop, exp_pc, exp_top, empty, full, miss
        vecs.push_back(mk(2'b10, 64'h0, 0,0,0,0, 64'h4, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,0,0, 64'h8, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,0,0, 64'hC, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,0, 64'hC, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b01, 64'h10, 0,0,0,0, 64'h10, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b11, 64'h3, 0,0,0,0, 64'h20, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b01, 64'h1000, 0,0,0,0, 64'h1000, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 0,0,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,0,0, 64'h0, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b11, 64'hC000_0000_0000_0001, 0,0,0,0, 64'h8, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b01, 64'h100, 0,0,0,0, 64'h100, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b11, 64'h40, 0,0,1,0, 64'h204, 64'h104, 0,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'h104, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b01, 64'h0, 0,0,0,0, 64'h0, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'h4, 64'h4, 0,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'h8, 64'h8, 0,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'hC, 64'hC, 0,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'h10, 64'h10, 0,1,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'h14, 64'h14, 0,1,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'h14, 64'h10, 0,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'h10, 64'hC, 0,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'hC, 64'h8, 0,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'h8, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b00, 64'h300, 0,0,0,1, 64'h300, 64'h0, 1,0,1));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,0, 64'h300, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'h304, 64'h304, 0,0,0));
        vecs.push_back(mk(2'b10, 64'h999, 1,1,1,1, 64'h80, 64'h304, 0,0,0));
        vecs.push_back(mk(2'b10, 64'h999, 1,0,0,1, 64'h80, 64'h304, 0,0,0));
        vecs.push_back(mk(2'b01, 64'h1FC, 0,0,0,0, 64'h1FC, 64'h304, 0,0,0));
        vecs.push_back(mk(2'b10, 64'h0, 0,0,1,0, 64'h200, 64'h200, 0,0,0));
        vecs.push_back(mk(2'b01, 64'h50, 0,0,0,0, 64'h50, 64'h200, 0,0,0));
        vecs.push_back(mk(2'b01, 64'h777, 0,0,1,1, 64'h200, 64'h54, 0,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'h54, 64'h304, 0,0,0));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,1, 64'h304, 64'h0, 1,0,0));
        vecs.push_back(mk(2'b10, 64'h400, 0,0,1,1, 64'h400, 64'h308, 0,0,1));
        vecs.push_back(mk(2'b00, 64'h0, 0,0,0,0, 64'h400, 64'h308, 0,0,0));

        PS = 2'b00; in = '0; stall = 0; trap = 0; push = 0; pop = 0;
        reset = 1'b1;
        #12;
        checkAll("reset", 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_top,
                     vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_miss);
        end

        // Bring the stack to three entries, then reset between edges.
        applyStimulus(mk(2'b10, 64'h0, 0,0,1,0, 64'h404, 64'h404, 0,0,0));
        checkAll("pre-reset push1", 64'h404, 64'h404, 1'b0, 1'b0, 1'b0);
        applyStimulus(mk(2'b10, 64'h0, 0,0,1,0, 64'h408, 64'h408, 0,0,0));
        checkAll("pre-reset push2", 64'h408, 64'h408, 1'b0, 1'b0, 1'b0);
        PS = 2'b10; push = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkAll("async reset", 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        push = 1'b0;
        reset = 1'b0;
        applyStimulus(mk(2'b10, 64'h0, 0,0,0,0, 64'h4, 64'h0, 1,0,0));
        checkAll("post reset", 64'h4, 64'h0, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
